// File: rtl/ex_stage.sv
// Execute stage: ALU or iterative shift-add unsigned multiply into the EX/MEM register.
// Optional macro EX_OVF_TRAP_EN: signed ADD/SUB overflow raises ovf_out and suppresses writeback.
module ex_stage #(
  parameter int unsigned MUL_BPC = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_en,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] rdat1_in,
  input  logic [31:0] rdat2_in,
  input  logic [31:0] immediate_in,
  input  logic        alusrc_in,
  input  logic [3:0]  aluop_in,
  input  logic        mul_in,
  input  logic        dWEN_in,
  input  logic        dREN_in,
  input  logic        WEN_in,
  input  logic        halt_in,
  input  logic        datomic_in,
  input  logic [4:0]  wsel_in,
  input  logic [1:0]  wdatsel_in,
  input  logic [31:0] npc_in,
  input  logic [31:0] lui_word_in,
  output logic        ex_stall,
  output logic [31:0] porto_out,
  output logic [31:0] dmemstore_out,
  output logic        valid_out,
  output logic        dWEN_out,
  output logic        dREN_out,
  output logic        WEN_out,
  output logic        halt_out,
  output logic        datomic_out,
  output logic [4:0]  wsel_out,
  output logic [1:0]  wdatsel_out,
  output logic [31:0] npc_out,
  output logic [31:0] lui_word_out,
  output logic        ovf_out
);

  localparam int unsigned MUL_STEPS = 32 / MUL_BPC;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_e;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef struct packed {
    logic        valid;
    logic        dwen;
    logic        dren;
    logic        wen;
    logic        halt;
    logic        datomic;
    logic        ovf;
    logic [4:0]  wsel;
    logic [1:0]  wdatsel;
    logic [31:0] porto;
    logic [31:0] dmemstore;
    logic [31:0] npc;
    logic [31:0] lui_word;
  } exmem_t;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
  exmem_t      exmem_q, exmem_d;

  logic [31:0] opb, alu_res, step_acc;
  exmem_t      pass_pkt, alu_pkt, mul_pkt;

  always_comb begin
    opb     = alusrc_in ? immediate_in : rdat2_in;
    alu_res = '0;
    case (aluop_e'(aluop_in))
      ALU_SLL:  alu_res = rdat1_in << opb[4:0];
      ALU_SRL:  alu_res = rdat1_in >> opb[4:0];
      ALU_ADD:  alu_res = rdat1_in + opb;
      ALU_SUB:  alu_res = rdat1_in - opb;
      ALU_AND:  alu_res = rdat1_in & opb;
      ALU_OR:   alu_res = rdat1_in | opb;
      ALU_XOR:  alu_res = rdat1_in ^ opb;
      ALU_NOR:  alu_res = ~(rdat1_in | opb);
      ALU_SLT:  alu_res = {31'd0, $signed(rdat1_in) < $signed(opb)};
      ALU_SLTU: alu_res = {31'd0, rdat1_in < opb};
      default:  alu_res = '0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  logic alu_ovf;
  always_comb begin
    alu_ovf = 1'b0;
    if (aluop_e'(aluop_in) == ALU_ADD)
      alu_ovf = (rdat1_in[31] == opb[31]) && (alu_res[31] != rdat1_in[31]);
    else if (aluop_e'(aluop_in) == ALU_SUB)
      alu_ovf = (rdat1_in[31] != opb[31]) && (alu_res[31] != rdat1_in[31]);
  end
`endif

  // Partial product for this cycle: MUL_BPC low bits of the shifted multiplier.
  always_comb begin
    step_acc = acc_q;
    for (int unsigned i = 0; i < MUL_BPC; i++)
      if (mb_q[i]) step_acc = step_acc + (ma_q << i);
  end

  always_comb begin
    pass_pkt           = '0;
    pass_pkt.valid     = 1'b1;
    pass_pkt.dwen      = dWEN_in;
    pass_pkt.dren      = dREN_in;
    pass_pkt.wen       = WEN_in;
    pass_pkt.halt      = halt_in;
    pass_pkt.datomic   = datomic_in;
    pass_pkt.wsel      = wsel_in;
    pass_pkt.wdatsel   = wdatsel_in;
    pass_pkt.dmemstore = rdat2_in;
    pass_pkt.npc       = npc_in;
    pass_pkt.lui_word  = lui_word_in;
    alu_pkt            = pass_pkt;
    alu_pkt.porto      = alu_res;
`ifdef EX_OVF_TRAP_EN
    alu_pkt.ovf        = alu_ovf;
    alu_pkt.wen        = WEN_in & ~alu_ovf;
`endif
    mul_pkt            = pass_pkt;
    mul_pkt.porto      = acc_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    exmem_d  = exmem_q;
    ex_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in && mul_in && !flush) begin
          ex_stall = 1'b1;
          ma_d     = rdat1_in;
          mb_d     = opb;
          acc_d    = '0;
          cnt_d    = 6'(MUL_STEPS);
          state_d  = S_BUSY;
          if (ex_en) exmem_d = '0;
        end else if (ex_en) begin
          exmem_d = valid_in ? alu_pkt : '0;
        end
      end
      S_BUSY: begin
        ex_stall = 1'b1;
        acc_d    = step_acc;
        ma_d     = ma_q << MUL_BPC;
        mb_d     = mb_q >> MUL_BPC;
        cnt_d    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_DONE;
        if (ex_en) exmem_d = '0;
      end
      S_DONE: begin
        ex_stall = ~ex_en;
        if (ex_en) begin
          exmem_d = mul_pkt;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      exmem_d = '0;
      state_d = S_IDLE;
      cnt_d   = '0;
    end
    if (RST) ex_stall = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      exmem_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      exmem_q <= exmem_d;
    end
  end

  assign porto_out     = exmem_q.porto;
  assign dmemstore_out = exmem_q.dmemstore;
  assign valid_out     = exmem_q.valid;
  assign dWEN_out      = exmem_q.dwen;
  assign dREN_out      = exmem_q.dren;
  assign WEN_out       = exmem_q.wen;
  assign halt_out      = exmem_q.halt;
  assign datomic_out   = exmem_q.datomic;
  assign wsel_out      = exmem_q.wsel;
  assign wdatsel_out   = exmem_q.wdatsel;
  assign npc_out       = exmem_q.npc;
  assign lui_word_out  = exmem_q.lui_word;
  assign ovf_out       = exmem_q.ovf;

endmodule
